// File: rtl/aes_round_key_store_128.sv
// AES-128 round key store: captures the cipher key and the ten expanded round keys.
// It then serves any round key through a one-cycle registered read port, in forward
// or reverse (decrypt) order.
module aes_round_key_store_128 (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] short_key,
    input  logic [127:0] subkey,
    input  logic [3:0]   cnt128,
    input  logic         valid_skey,
    input  logic         rd_en,
    input  logic [3:0]   rd_round,
    input  logic         rd_rev,
    output logic [127:0] rd_key,
    output logic         rd_valid,
    output logic         rd_err,
    output logic         keys_ready,
    output logic         busy
);

    localparam int unsigned NumSlots = 11;
    localparam logic [10:0] MaskFull = 11'h7ff;

    typedef enum logic [1:0] {StIdle, StLoad, StReady} state_e;

    state_e        state_q, state_d;
    logic [127:0]  slot_q [NumSlots];
    logic [10:0]   mask_q, mask_d;
    logic          wr_en;
    logic [10:0]   wr_onehot;
    logic [3:0]    rd_phys;
    logic          rd_ok;
    logic [127:0]  rd_data;

    // Decode an expander write; start wins over a coincident valid_skey
    always_comb begin
        wr_onehot = '0;
        wr_en     = (state_q == StLoad) && valid_skey && !start &&
                    (cnt128 >= 4'd1) && (cnt128 <= 4'd10);
        for (int i = 1; i < NumSlots; i++) begin
            if (wr_en && (cnt128 == 4'(i))) begin
                wr_onehot[i] = 1'b1;
            end
        end
    end

    // Next write mask: a new load only knows slot 0
    always_comb begin
        if (start) begin
            mask_d = 11'h001;
        end else begin
            mask_d = mask_q | wr_onehot;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = StLoad;
        end else if ((state_q == StLoad) && (mask_d == MaskFull)) begin
            state_d = StReady;
        end
    end

    // State-decoded outputs
    always_comb begin
        busy       = (state_q == StLoad);
        keys_ready = (state_q == StReady);
    end

    // Write mask register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    // Key slots; slots 1..10 keep stale data across a restart, masked by keys_ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NumSlots; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            if (start) begin
                slot_q[0] <= short_key;
            end
            for (int i = 1; i < NumSlots; i++) begin
                if (wr_onehot[i]) begin
                    slot_q[i] <= subkey;
                end
            end
        end
    end

    // Read address translation and slot mux; out-of-range indices select nothing
    always_comb begin
        rd_phys = rd_rev ? (4'd10 - rd_round) : rd_round;
        rd_ok   = keys_ready && (rd_round <= 4'd10);
        rd_data = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (rd_phys == 4'(i)) begin
                rd_data = slot_q[i];
            end
        end
    end

    // Registered read port; pre-edge slot contents give read-before-write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_key   <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_en && rd_ok;
            rd_err   <= rd_en && !rd_ok;
            if (rd_en && rd_ok) begin
                rd_key <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_aes_round_key_store_128.sv
// Testbench for aes_round_key_store_128: a behavioural AES-128 key expander feeds the store,
// and read results are checked against a queue of expected responses.
module tb_aes_round_key_store_128;

    localparam logic [127:0] KeyA  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] R1A   = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] R10A  = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    localparam logic [127:0] R10Z  = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] short_key;
    logic [127:0] subkey;
    logic [3:0]   cnt128;
    logic         valid_skey;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic         rd_rev;
    logic [127:0] rd_key;
    logic         rd_valid;
    logic         rd_err;
    logic         keys_ready;
    logic         busy;

    typedef struct {
        string        tag;
        logic         valid;
        logic         err;
        logic [127:0] key;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] last_key;
    int           n_checks;
    int           n_fail;
    int           pulses;

    aes_round_key_store_128 dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .short_key  (short_key),
        .subkey     (subkey),
        .cnt128     (cnt128),
        .valid_skey (valid_skey),
        .rd_en      (rd_en),
        .rd_round   (rd_round),
        .rd_rev     (rd_rev),
        .rd_key     (rd_key),
        .rd_valid   (rd_valid),
        .rd_err     (rd_err),
        .keys_ready (keys_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GF(2^8) multiply with the AES polynomial
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from first principles: inverse (a^254) then affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
               ^ 8'h63;
    endfunction

    // Round key n of the AES-128 schedule for key k (n=0 gives k)
    function automatic logic [127:0] round_key(input logic [127:0] k, input int n);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        {w0, w1, w2, w3} = k;
        rc = 8'h01;
        for (int r = 1; r <= n; r++) begin
            t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
                 ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
            w0 = w0 ^ t;
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
        end
        return {w0, w1, w2, w3};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive a read for the next edge and queue its expected response
    task automatic rd(input string tag, input logic [3:0] round, input logic rev,
                      input logic ok, input logic [127:0] key);
        exp_t e;
        rd_en    = 1'b1;
        rd_round = round;
        rd_rev   = rev;
        if (ok) last_key = key;
        e.tag   = tag;
        e.valid = ok;
        e.err   = !ok;
        e.key   = last_key;
        sb.push_back(e);
    endtask

    // One clock edge, then compare the read port against the scoreboard
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chkb({e.tag, "_valid"}, rd_valid, e.valid);
            chkb({e.tag, "_err"}, rd_err, e.err);
            chk({e.tag, "_key"}, rd_key, e.key);
        end else begin
            chkb("idle_valid", rd_valid, 1'b0);
            chkb("idle_err", rd_err, 1'b0);
        end
    endtask

    task automatic present(input logic [127:0] k, input int r);
        subkey     = round_key(k, r);
        cnt128     = 4'(r);
        valid_skey = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_key"}, rd_key, '0);
        chkb({tag, "_rd_valid"}, rd_valid, 1'b0);
        chkb({tag, "_rd_err"}, rd_err, 1'b0);
        chkb({tag, "_keys_ready"}, keys_ready, 1'b0);
        chkb({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        last_key   = '0;
        reset      = 1'b1;
        start      = 1'b0;
        short_key  = '0;
        subkey     = '0;
        cnt128     = '0;
        valid_skey = 1'b0;
        rd_en      = 1'b0;
        rd_round   = '0;
        rd_rev     = 1'b0;
        #2;
        chk_all_zero("reset");
        #10 reset = 1'b0;

        // Basic load of key A, with a rejected read during LOAD
        start     = 1'b1;
        short_key = KeyA;
        step();
        start     = 1'b0;
        short_key = '0;
        chkb("load_busy", busy, 1'b1);
        chkb("load_ready", keys_ready, 1'b0);
        for (int r = 1; r <= 10; r++) begin
            present(KeyA, r);
            if (r == 3) rd("rd_in_load", 4'd0, 1'b0, 1'b0, '0);
            step();
            rd_en = 1'b0;
            chkb("ready_edge", keys_ready, r == 10);
            chkb("busy_edge", busy, r != 10);
        end
        // Expander trailing cycle in READY must not corrupt slot 10
        subkey = '1;
        cnt128 = 4'd10;
        step();
        valid_skey = 1'b0;
        cnt128     = '0;
        subkey     = '0;
        chkb("ready_hold", keys_ready, 1'b1);

        rd("fwd_r1", 4'd1, 1'b0, 1'b1, R1A);
        step();
        rd("fwd_r10", 4'd10, 1'b0, 1'b1, R10A);
        step();
        rd("rev_0", 4'd0, 1'b1, 1'b1, R10A);
        step();
        rd("rev_10", 4'd10, 1'b1, 1'b1, KeyA);
        step();

        pulses = 0;
        for (int i = 0; i <= 10; i++) begin
            rd("sweep", 4'(i), 1'b0, 1'b1, round_key(KeyA, i));
            step();
            if (rd_valid) pulses++;
        end
        rd_en = 1'b0;
        step();
        chk("sweep_pulses", 128'(pulses), 128'd11);

        rd("rej_r11", 4'd11, 1'b0, 1'b0, '0);
        step();
        rd("rej_r15_rev", 4'd15, 1'b1, 1'b0, '0);
        step();
        rd_en = 1'b0;
        step();

        // Read coincident with start in READY returns the old round 0
        rd("rd_at_start", 4'd0, 1'b0, 1'b1, KeyA);
        start     = 1'b1;
        short_key = '0;
        step();
        rd_en = 1'b0;
        start = 1'b0;
        chkb("restart_ready", keys_ready, 1'b0);
        chkb("restart_busy", busy, 1'b1);
        for (int r = 1; r <= 4; r++) begin
            present('0, r);
            step();
            chkb("first_load_ready", keys_ready, 1'b0);
        end
        // Second start at load cycle 5 while the expander still presents data
        start      = 1'b1;
        short_key  = '0;
        subkey     = '1;
        cnt128     = 4'd5;
        valid_skey = 1'b1;
        step();
        start = 1'b0;
        chkb("second_start_ready", keys_ready, 1'b0);
        chkb("second_start_busy", busy, 1'b1);
        for (int r = 1; r <= 10; r++) begin
            present('0, r);
            step();
            chkb("reload_ready", keys_ready, r == 10);
        end
        valid_skey = 1'b0;
        rd("zero_r10", 4'd10, 1'b0, 1'b1, R10Z);
        step();
        rd("zero_rev10", 4'd10, 1'b1, 1'b1, '0);
        step();
        rd_en = 1'b0;

        // Asynchronous reset in the middle of a load
        start     = 1'b1;
        short_key = KeyA;
        step();
        start = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            present(KeyA, r);
            step();
        end
        #3 reset = 1'b1;
        #1;
        last_key = '0;
        chk_all_zero("async_reset");
        step();
        #3 reset = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            present(KeyA, r);
            step();
            chkb("no_start_ready", keys_ready, 1'b0);
            chkb("no_start_busy", busy, 1'b0);
        end
        valid_skey = 1'b0;
        rd("rd_after_reset", 4'd0, 1'b0, 1'b0, '0);
        step();
        rd_en = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
